// File: rtl/usb_ep_arbiter.sv
// ---------------------------------------------------------------------------
// usb_ep_arbiter
//
// Per-transaction scheduler between the USB core's single-endpoint datapath
// and NUM_EP endpoint handlers (EP0 control plus application endpoints).
// Each token is decoded once: the endpoint/direction/setup are latched, the
// handshake is chosen, and the byte streams are routed to or from the chosen
// handler. The arbiter owns every endpoint's IN and OUT data-toggle bit.
//
// Optional build macro: USB_EP_ARB_STATS_EN adds saturating NAK/STALL
// counters (o_nak_count, o_stall_count).
//
// Ports:
//   clk48mhz               clock, every signal is in this domain
//   rst                    synchronous active-low reset
//   i_usb_rst              bus reset from the core, same effect as rst
//   i_transaction_active   core transaction in progress
//   i_endpoint             token endpoint number
//   i_direction_in         token is IN
//   i_setup                token is SETUP
//   i_success              CRC ok (OUT) or host ACK (IN)
//   i_data_strobe          byte accepted (IN) / delivered (OUT) by the core
//   i_data_out             OUT byte from the core
//   o_handshake            00 ACK, 01 none, 10 NAK, 11 STALL
//   o_data_toggle          data PID toggle for the current transaction
//   o_data_in/_valid       IN byte stream to the core
//   i_ep_in_ready          handler has IN data for the next transaction
//   i_ep_out_ready         handler can accept an OUT packet
//   i_ep_stall             handler requests STALL
//   i_ep_in_data           per-endpoint IN byte, endpoint k at [8k+7:8k]
//   i_ep_in_valid          per-endpoint IN byte valid (low = end of packet)
//   o_ep_in_strobe         core consumed the current IN byte
//   o_ep_out_data/_strobe  registered OUT byte and its one-hot pulse
//   o_ep_setup             current transaction is SETUP for that endpoint
//   o_ep_done/_ok          transaction-end pulse and its success qualifier
// ---------------------------------------------------------------------------
module usb_ep_arbiter #(
  parameter int NUM_EP = 3
) (
  input  logic                  clk48mhz,
  input  logic                  rst,
  input  logic                  i_usb_rst,
  input  logic                  i_transaction_active,
  input  logic [3:0]            i_endpoint,
  input  logic                  i_direction_in,
  input  logic                  i_setup,
  input  logic                  i_success,
  input  logic                  i_data_strobe,
  input  logic [7:0]            i_data_out,
  output logic [1:0]            o_handshake,
  output logic                  o_data_toggle,
  output logic [7:0]            o_data_in,
  output logic                  o_data_in_valid,
  input  logic [NUM_EP-1:0]     i_ep_in_ready,
  input  logic [NUM_EP-1:0]     i_ep_out_ready,
  input  logic [NUM_EP-1:0]     i_ep_stall,
  input  logic [8*NUM_EP-1:0]   i_ep_in_data,
  input  logic [NUM_EP-1:0]     i_ep_in_valid,
  output logic [NUM_EP-1:0]     o_ep_in_strobe,
  output logic [7:0]            o_ep_out_data,
  output logic [NUM_EP-1:0]     o_ep_out_strobe,
  output logic [NUM_EP-1:0]     o_ep_setup,
  output logic [NUM_EP-1:0]     o_ep_done,
  output logic                  o_ep_done_ok
`ifdef USB_EP_ARB_STATS_EN
  ,
  output logic [15:0]           o_nak_count,
  output logic [15:0]           o_stall_count
`endif
);

  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;
  localparam logic [4:0] EP_LIMIT = 5'(NUM_EP);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t              r_state;
  logic                r_ta_d;
  logic                r_success_d;
  logic [3:0]          r_cur_ep;
  logic                r_dir_in;
  logic                r_setup;
  logic                r_success_seen;
  logic [1:0]          r_handshake;
  logic                r_data_toggle;
  logic [NUM_EP-1:0]   r_tog_in;
  logic [NUM_EP-1:0]   r_tog_out;
  logic [NUM_EP-1:0]   r_ep_out_strobe;
  logic [7:0]          r_ep_out_data;
  logic [NUM_EP-1:0]   r_ep_done;
  logic                r_ep_done_ok;
`ifdef USB_EP_ARB_STATS_EN
  logic [15:0]         r_nak_count;
  logic [15:0]         r_stall_count;
`endif

  logic                w_rst;
  logic                w_ta_rise;
  logic                w_dec_valid;
  logic [NUM_EP-1:0]   w_dec_onehot;
  logic [NUM_EP-1:0]   w_cur_onehot;
  logic                w_dec_stall;
  logic                w_dec_in_rdy;
  logic                w_dec_out_rdy;
  logic                w_dec_tog_in;
  logic                w_dec_tog_out;
  logic [1:0]          w_dec_handshake;
  logic                w_dec_toggle;
  logic [7:0]          w_in_byte;
  logic                w_in_valid_sel;
  logic                w_ack_active;
  logic                w_in_route;
  logic                w_out_route;
  logic                w_succ_ack;

  assign w_rst     = !rst || i_usb_rst;
  assign w_ta_rise = i_transaction_active && !r_ta_d;

  // One-hot endpoint decodes (endpoints >= NUM_EP decode to all zeros) and IN byte mux.
  always_comb begin
    w_dec_onehot   = '0;
    w_cur_onehot   = '0;
    w_in_byte      = 8'h00;
    w_in_valid_sel = 1'b0;
    for (int k = 0; k < NUM_EP; k++) begin
      w_dec_onehot[k] = (i_endpoint == 4'(k));
      w_cur_onehot[k] = (r_cur_ep == 4'(k));
      w_in_byte       = w_in_byte | (i_ep_in_data[8*k +: 8] & {8{w_cur_onehot[k]}});
      w_in_valid_sel  = w_in_valid_sel | (i_ep_in_valid[k] & w_cur_onehot[k]);
    end
  end

  assign w_dec_valid   = ({1'b0, i_endpoint} < EP_LIMIT);
  assign w_dec_stall   = |(w_dec_onehot & i_ep_stall);
  assign w_dec_in_rdy  = |(w_dec_onehot & i_ep_in_ready);
  assign w_dec_out_rdy = |(w_dec_onehot & i_ep_out_ready);
  assign w_dec_tog_in  = |(w_dec_onehot & r_tog_in);
  assign w_dec_tog_out = |(w_dec_onehot & r_tog_out);

  // Handshake priority: unimplemented endpoint, SETUP (never refused), stall, not-ready.
  always_comb begin
    if (!w_dec_valid) begin
      w_dec_handshake = HS_STALL;
    end else if (i_setup) begin
      w_dec_handshake = HS_ACK;
    end else if (w_dec_stall) begin
      w_dec_handshake = HS_STALL;
    end else if (i_direction_in && !w_dec_in_rdy) begin
      w_dec_handshake = HS_NAK;
    end else if (!i_direction_in && !w_dec_out_rdy) begin
      w_dec_handshake = HS_NAK;
    end else begin
      w_dec_handshake = HS_ACK;
    end
  end

  // SETUP always uses DATA0; otherwise the stored toggle of the addressed direction.
  assign w_dec_toggle = i_setup ? 1'b0 : (i_direction_in ? w_dec_tog_in : w_dec_tog_out);

  // Data routing is only open while an ACKed transaction is in flight.
  assign w_ack_active = (r_state == ST_ACTIVE) && (r_handshake == HS_ACK);
  assign w_in_route   = w_ack_active && r_dir_in;
  assign w_out_route  = w_ack_active && !r_dir_in;
  assign w_succ_ack   = w_ack_active && i_success && !r_success_d;

  assign o_data_in       = w_in_route ? w_in_byte : 8'h00;
  assign o_data_in_valid = w_in_route && w_in_valid_sel;
  assign o_ep_in_strobe  = w_cur_onehot & {NUM_EP{w_in_route && i_data_strobe}};

  // During DECODE the token is not latched yet, so the live token drives ep_setup.
  always_comb begin
    case (r_state)
      ST_DECODE: o_ep_setup = w_dec_onehot & {NUM_EP{i_setup}};
      ST_ACTIVE,
      ST_DONE:   o_ep_setup = w_cur_onehot & {NUM_EP{r_setup}};
      default:   o_ep_setup = '0;
    endcase
  end

  assign o_handshake     = r_handshake;
  assign o_data_toggle   = r_data_toggle;
  assign o_ep_out_strobe = r_ep_out_strobe;
  assign o_ep_out_data   = r_ep_out_data;
  assign o_ep_done       = r_ep_done;
  assign o_ep_done_ok    = r_ep_done_ok;
`ifdef USB_EP_ARB_STATS_EN
  assign o_nak_count     = r_nak_count;
  assign o_stall_count   = r_stall_count;
`endif

  // Transaction FSM with its registered outputs and the per-endpoint toggle store.
  always_ff @(posedge clk48mhz) begin
    if (w_rst) begin
      r_state         <= ST_IDLE;
      // Track the live level so a transaction still active after reset is not re-decoded.
      r_ta_d          <= i_transaction_active;
      r_success_d     <= i_success;
      r_cur_ep        <= 4'd0;
      r_dir_in        <= 1'b0;
      r_setup         <= 1'b0;
      r_success_seen  <= 1'b0;
      r_handshake     <= HS_ACK;
      r_data_toggle   <= 1'b0;
      r_tog_in        <= '0;
      r_tog_out       <= '0;
      r_ep_out_strobe <= '0;
      r_ep_out_data   <= 8'h00;
      r_ep_done       <= '0;
      r_ep_done_ok    <= 1'b0;
`ifdef USB_EP_ARB_STATS_EN
      r_nak_count     <= 16'h0000;
      r_stall_count   <= 16'h0000;
`endif
    end else begin
      r_ta_d          <= i_transaction_active;
      r_success_d     <= i_success;
      r_ep_out_strobe <= '0;
      r_ep_done       <= '0;
      r_ep_done_ok    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ta_rise) begin
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_cur_ep       <= i_endpoint;
          r_dir_in       <= i_direction_in;
          r_setup        <= i_setup;
          r_handshake    <= w_dec_handshake;
          r_data_toggle  <= w_dec_toggle;
          r_success_seen <= 1'b0;
`ifdef USB_EP_ARB_STATS_EN
          if ((w_dec_handshake == HS_NAK) && (r_nak_count != 16'hFFFF)) begin
            r_nak_count <= r_nak_count + 16'd1;
          end
          if ((w_dec_handshake == HS_STALL) && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
          end
`endif
          r_state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_out_route && i_data_strobe) begin
            r_ep_out_strobe <= w_cur_onehot;
            r_ep_out_data   <= i_data_out;
          end
          if (w_succ_ack) begin
            r_success_seen <= 1'b1;
          end
          if (!i_transaction_active) begin
            // A success edge in the final cycle still counts.
            r_ep_done    <= w_cur_onehot;
            r_ep_done_ok <= (r_success_seen || w_succ_ack) && (|w_cur_onehot);
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (r_success_seen) begin
            for (int k = 0; k < NUM_EP; k++) begin
              if (w_cur_onehot[k]) begin
                if (r_setup) begin
                  r_tog_in[k]  <= 1'b1;
                  r_tog_out[k] <= 1'b1;
                end else if (r_dir_in) begin
                  r_tog_in[k]  <= ~r_tog_in[k];
                end else begin
                  r_tog_out[k] <= ~r_tog_out[k];
                end
              end
            end
          end
          r_state <= w_ta_rise ? ST_DECODE : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_ep_arbiter.sv
module tb_usb_ep_arbiter;
  localparam int NUM_EP = 3;

  logic clk48mhz = 1'b0;
  logic rst = 1'b0, usb_rst = 1'b0, ta = 1'b0;
  logic [3:0] ep = 4'd0;
  logic din = 1'b0, setup = 1'b0, success = 1'b0, dstb = 1'b0;
  logic [7:0] dout = 8'h00;
  logic [NUM_EP-1:0] in_rdy = '0, out_rdy = '0, stall = '0, in_valid = '0;
  logic [8*NUM_EP-1:0] in_data = '0;
  logic [1:0] handshake;
  logic data_toggle, data_in_valid, ep_done_ok;
  logic [7:0] data_in, ep_out_data;
  logic [NUM_EP-1:0] ep_in_strobe, ep_out_strobe, ep_setup, ep_done;
`ifdef USB_EP_ARB_STATS_EN
  logic [15:0] nak_count, stall_count;
`endif

  usb_ep_arbiter #(.NUM_EP(NUM_EP)) dut (
    .clk48mhz(clk48mhz), .rst(rst), .i_usb_rst(usb_rst),
    .i_transaction_active(ta), .i_endpoint(ep), .i_direction_in(din),
    .i_setup(setup), .i_success(success), .i_data_strobe(dstb),
    .i_data_out(dout), .o_handshake(handshake), .o_data_toggle(data_toggle),
    .o_data_in(data_in), .o_data_in_valid(data_in_valid),
    .i_ep_in_ready(in_rdy), .i_ep_out_ready(out_rdy), .i_ep_stall(stall),
    .i_ep_in_data(in_data), .i_ep_in_valid(in_valid),
    .o_ep_in_strobe(ep_in_strobe), .o_ep_out_data(ep_out_data),
    .o_ep_out_strobe(ep_out_strobe), .o_ep_setup(ep_setup),
    .o_ep_done(ep_done), .o_ep_done_ok(ep_done_ok)
`ifdef USB_EP_ARB_STATS_EN
    , .o_nak_count(nak_count), .o_stall_count(stall_count)
`endif
  );

  always #5 clk48mhz = ~clk48mhz;

  // Pulse monitor: counts strobes/done pulses on the falling edge.
  int out_cnt [NUM_EP];
  int in_cnt [NUM_EP];
  int done_cnt [NUM_EP];
  int ok_cnt [NUM_EP];
  int dv_cnt = 0;
  logic [7:0] out_q [$];
  always @(negedge clk48mhz) begin
    for (int k = 0; k < NUM_EP; k++) begin
      if (ep_out_strobe[k]) begin out_cnt[k]++; out_q.push_back(ep_out_data); end
      if (ep_in_strobe[k]) in_cnt[k]++;
      if (ep_done[k]) begin done_cnt[k]++; if (ep_done_ok) ok_cnt[k]++; end
    end
    if (data_in_valid) dv_cnt++;
  end

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: toggle bits per endpoint/direction and event counts.
  int m_tog_in [16];
  int m_tog_out [16];
  int m_nak = 0, m_stall = 0;

  function automatic logic [1:0] model_hs(input int e, input bit d, input bit s);
    if (e >= NUM_EP) return 2'b11;
    if (s) return 2'b00;
    if (stall[e]) return 2'b11;
    if (d ? !in_rdy[e] : !out_rdy[e]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int model_tog(input int e, input bit d, input bit s);
    if (s || e >= NUM_EP) return 0;
    return d ? m_tog_in[e] : m_tog_out[e];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin m_tog_in[k] = 0; m_tog_out[k] = 0; end
    m_nak = 0; m_stall = 0;
  endtask

  task automatic step();
    @(posedge clk48mhz); #1;
  endtask

  // One full transaction. ehs/etog are the expected handshake/toggle;
  // chain leaves the arbiter in DONE so the next token starts there.
  task automatic txn(input int e, input bit d, input bit s, input int nb, input bit sc,
                     input bit late, input bit chain, input logic [1:0] ehs,
                     input int etog, input string tag);
    int o0 [NUM_EP];
    int i0 [NUM_EP];
    int d0 [NUM_EP];
    int k0 [NUM_EP];
    int dv0, q0;
    logic [1:0] mhs;
    logic [NUM_EP-1:0] oh;
    logic [7:0] bv, lane;
    bit acked;
    o0 = out_cnt; i0 = in_cnt; d0 = done_cnt; k0 = ok_cnt; dv0 = dv_cnt; q0 = out_q.size();
    mhs = model_hs(e, d, s);
    acked = (mhs == 2'b00);
    oh = '0;
    if (e < NUM_EP) oh[e] = 1'b1;
    ta = 1'b1; ep = 4'(e); din = d; setup = s;
    step(); step();
    chk({tag, ".hs"}, handshake, ehs);
    chk({tag, ".tog"}, data_toggle, etog);
    chk({tag, ".setup"}, ep_setup, s ? oh : '0);
    // Readiness changes after decode must not matter.
    in_rdy = NUM_EP'($urandom); out_rdy = NUM_EP'($urandom);
    for (int b = 0; b < nb; b++) begin
      bv = 8'h30 + 8'(b);
      if (d) begin
        in_valid = '1;
        for (int k = 0; k < NUM_EP; k++) begin
          lane = bv ^ 8'(16 * k);
          in_data[8*k +: 8] = lane;
        end
        dstb = 1'b1; #1;
        if (acked) begin
          lane = bv ^ 8'(16 * e);
          chk({tag, ".din"}, data_in, lane);
        end
      end else begin
        dout = 8'hA0 + 8'(b); dstb = 1'b1;
      end
      step();
    end
    dstb = 1'b0; in_valid = '0;
    if (sc && !late) begin success = 1'b1; step(); success = 1'b0; end
    ta = 1'b0;
    if (sc && late) success = 1'b1;
    step();
    success = 1'b0;
    #6;
    for (int k = 0; k < NUM_EP; k++) begin
      chk({tag, ".outstb"}, out_cnt[k] - o0[k], (acked && !d && k == e) ? nb : 0);
      chk({tag, ".instb"}, in_cnt[k] - i0[k], (acked && d && k == e) ? nb : 0);
      chk({tag, ".done"}, done_cnt[k] - d0[k], (k == e) ? 1 : 0);
      chk({tag, ".ok"}, ok_cnt[k] - k0[k], (k == e && acked && sc) ? 1 : 0);
    end
    chk({tag, ".dv"}, dv_cnt - dv0, (acked && d) ? nb : 0);
    if (acked && !d) begin
      for (int b = 0; b < nb; b++) begin
        bv = 8'hA0 + 8'(b);
        chk({tag, ".obyte"}, (q0 + b < out_q.size()) ? out_q[q0 + b] : 8'hxx, bv);
      end
    end
    if (acked && sc) begin
      if (s) begin m_tog_in[e] = 1; m_tog_out[e] = 1; end
      else if (d) m_tog_in[e] = 1 - m_tog_in[e];
      else m_tog_out[e] = 1 - m_tog_out[e];
    end
    if (mhs == 2'b10) m_nak++;
    if (mhs == 2'b11) m_stall++;
    if (!chain) step();
  endtask

  typedef struct {
    int ep; bit din; bit setup; int nb; bit sc; bit late;
    logic [NUM_EP-1:0] in_rdy; logic [NUM_EP-1:0] out_rdy; logic [NUM_EP-1:0] stall;
    logic [1:0] hs; int tog;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int e, nb;
    bit d, s, sc, late, chain;
    tbl[0]  = '{0, 1'b0, 1'b1, 8, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 2'b00, 0};
    tbl[1]  = '{1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 3'b010, 3'b000, 3'b000, 2'b00, 0};
    tbl[2]  = '{1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 3'b010, 3'b000, 3'b000, 2'b00, 1};
    tbl[3]  = '{2, 1'b1, 1'b0, 2, 1'b1, 1'b0, 3'b011, 3'b111, 3'b000, 2'b10, 0};
    tbl[4]  = '{5, 1'b0, 1'b0, 2, 1'b1, 1'b0, 3'b111, 3'b111, 3'b000, 2'b11, 0};
    tbl[5]  = '{1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 3'b111, 3'b111, 3'b010, 2'b11, 0};
    tbl[6]  = '{1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 2'b00, 0};
    tbl[7]  = '{1, 1'b1, 1'b0, 3, 1'b1, 1'b1, 3'b010, 3'b000, 3'b000, 2'b00, 0};
    tbl[8]  = '{0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 3'b000, 3'b001, 3'b000, 2'b00, 1};
    tbl[9]  = '{0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 3'b111, 3'b000, 3'b000, 2'b10, 0};
    tbl[10] = '{2, 1'b0, 1'b1, 8, 1'b1, 1'b0, 3'b000, 3'b000, 3'b100, 2'b00, 0};
    tbl[11] = '{2, 1'b1, 1'b0, 2, 1'b1, 1'b0, 3'b100, 3'b000, 3'b000, 2'b00, 1};

    model_reset();
    rst = 1'b0;
    step(); step(); step();
    chk("rst.hs", handshake, 2'b00);
    chk("rst.tog", data_toggle, 1'b0);
    chk("rst.din", data_in, 8'h00);
    chk("rst.dv", data_in_valid, 1'b0);
    chk("rst.pulses", {ep_in_strobe, ep_out_strobe, ep_done, ep_setup}, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      in_rdy = tbl[i].in_rdy; out_rdy = tbl[i].out_rdy; stall = tbl[i].stall;
      txn(tbl[i].ep, tbl[i].din, tbl[i].setup, tbl[i].nb, tbl[i].sc, tbl[i].late,
          1'b0, tbl[i].hs, tbl[i].tog, $sformatf("vec%0d", i));
    end
    chk("vec.ep0_in_tog", m_tog_in[0], 1);

    // Token arriving while in DONE: the toggle from the previous success must apply.
    stall = '0; in_rdy = 3'b010;
    txn(1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b1, 2'b00, model_tog(1, 1'b1, 1'b0), "b2b_a");
    in_rdy = 3'b010;
    txn(1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 2'b00, model_tog(1, 1'b1, 1'b0), "b2b_b");

    // Bus reset in ACTIVE: aborts without a done pulse and clears all toggles.
    begin
      int d1;
      d1 = done_cnt[1];
      in_rdy = 3'b010;
      ta = 1'b1; ep = 4'd1; din = 1'b1; setup = 1'b0;
      step(); step();
      chk("ures.tog_before", data_toggle, 1'b1);
      step();
      usb_rst = 1'b1; step(); usb_rst = 1'b0;
      chk("ures.hs", handshake, 2'b00);
      chk("ures.tog", data_toggle, 1'b0);
      step(); ta = 1'b0; step(); step(); step();
      chk("ures.nodone", done_cnt[1] - d1, 0);
      model_reset();
    end
    in_rdy = 3'b010;
    txn(1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2'b00, 0, "post_rst_in");
    out_rdy = 3'b001;
    txn(0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 2'b00, 0, "post_rst_out");
    for (int i = 0; i < 3; i++) begin
      in_rdy = '0;
      txn(2, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2'b10, 0, "nak3");
    end
`ifdef USB_EP_ARB_STATS_EN
    chk("stats.nak3", nak_count, 3);
`endif

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      e = $urandom_range(0, 5);
      s = ($urandom_range(0, 5) == 0);
      d = s ? 1'b0 : 1'($urandom_range(0, 1));
      nb = $urandom_range(0, 4);
      sc = 1'($urandom_range(0, 1));
      late = 1'($urandom_range(0, 1));
      chain = 1'($urandom_range(0, 1));
      in_rdy = NUM_EP'($urandom); out_rdy = NUM_EP'($urandom);
      stall = ($urandom_range(0, 3) == 0) ? NUM_EP'($urandom) : '0;
      txn(e, d, s, nb, sc, late, chain, model_hs(e, d, s), model_tog(e, d, s),
          $sformatf("rnd%0d", i));
    end
    step();
`ifdef USB_EP_ARB_STATS_EN
    chk("stats.nak", nak_count, m_nak);
    chk("stats.stall", stall_count, m_stall);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
